// File: rtl/aes_sched_pkg.sv
// Shared defaults, pointer-width helper and FIPS-197 reference vectors for
// the AES pipeline scheduler.
package aes_sched_pkg;

  localparam int ID_W_DEF   = 2;
  localparam int DATA_W_DEF = 128;
  localparam int KEY_L_DEF  = 128;

  // FIPS-197 Appendix C.1 AES-128 example vector
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Bits needed to index 'value' entries, never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/aes_pipe_scheduler_if.sv
// Requester-side bus of the scheduler: per-requester request slices plus the
// shared tagged response port.
interface aes_pipe_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 128,
  parameter int KEY_L  = 128
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*KEY_L-1:0]  req_key;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    resp_valid;
  logic [ID_W-1:0]         resp_id;
  logic [DATA_W-1:0]       resp_data;

  modport master (
    output req_valid, req_key, req_data,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_key, req_data,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/aes_tag_fifo.sv
// In-order FIFO of requester IDs for blocks in flight through the cipher;
// push and pop may happen in the same cycle.
module aes_tag_fifo
  import aes_sched_pkg::*;
#(
  parameter int WIDTH = ID_W_DEF,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];

  // Explicit wrap so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_scheduler.sv
// Round-robin sharing of one pipelined AES cipher among N_REQ requesters,
// with in-order tag tracking to route each ciphertext back to its owner.
module aes_pipe_scheduler
  import aes_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = ID_W_DEF,
  parameter int TAG_DEPTH = 64,
  parameter int MAX_OUT   = 16,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEY_L     = KEY_L_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  aes_pipe_scheduler_if.slave  bus,
  output logic                 cph_data_valid,
  output logic                 cph_key_valid,
  output logic [KEY_L-1:0]     cph_key,
  output logic [DATA_W-1:0]    cph_text,
  input  logic                 cph_valid_out,
  input  logic [DATA_W-1:0]    cph_cipher_text,
  output logic                 busy,
  output logic                 err_underflow,
  output logic [31:0]          issue_count
);

  localparam int CNT_W = clog2(MAX_OUT + 1);

  logic [ID_W-1:0]   rr_ptr_reg;
  logic [CNT_W-1:0]  out_cnt_reg [N_REQ];
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant_vec;
  logic [ID_W-1:0]   grant_idx;
  logic              transfer;
  logic [KEY_L-1:0]  sel_key;
  logic [DATA_W-1:0] sel_text;

  logic              issue_valid_reg;
  logic [KEY_L-1:0]  key_reg;
  logic [DATA_W-1:0] text_reg;
  logic              resp_valid_reg;
  logic [ID_W-1:0]   resp_id_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic              err_reg;
  logic [31:0]       issue_count_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;
  logic              pop;

  // A pop in the same cycle does not free a slot for this cycle's grant
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
      assign eligible[gi] = bus.req_valid[gi] & enable & ~fifo_full &
                            (out_cnt_reg[gi] < CNT_W'(MAX_OUT));
    end
  endgenerate

  // Scan offsets from the far end so the nearest eligible index overrides
  always_comb begin
    logic [ID_W:0] idx_wide;
    logic [ID_W-1:0] idx;
    grant_vec = '0;
    grant_idx = '0;
    idx_wide  = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_wide = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
      if (idx_wide >= (ID_W + 1)'(N_REQ)) idx_wide = idx_wide - (ID_W + 1)'(N_REQ);
      idx = idx_wide[ID_W-1:0];
      if (eligible[idx]) begin
        grant_vec      = '0;
        grant_vec[idx] = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  always_comb begin
    sel_key  = '0;
    sel_text = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_key  = bus.req_key[i*KEY_L +: KEY_L];
        sel_text = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer      = |(bus.req_valid & grant_vec);
  assign bus.req_ready = grant_vec;
  assign pop           = cph_valid_out & ~fifo_empty;

  aes_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (transfer),
    .push_data (grant_idx),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg      <= '0;
      issue_valid_reg <= 1'b0;
      key_reg         <= '0;
      text_reg        <= '0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= '0;
      resp_data_reg   <= '0;
      err_reg         <= 1'b0;
      issue_count_reg <= '0;
    end else begin
      issue_valid_reg <= transfer;
      resp_valid_reg  <= pop;
      if (transfer) begin
        rr_ptr_reg      <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        key_reg         <= sel_key;
        text_reg        <= sel_text;
        issue_count_reg <= issue_count_reg + 32'd1;
      end
      if (pop) begin
        resp_id_reg   <= fifo_head;
        resp_data_reg <= cph_cipher_text;
      end
      // Cipher output with nothing tracked: flag and drop
      if (cph_valid_out && fifo_empty) err_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic inc;
      logic dec;
      assign inc = transfer & grant_vec[gi];
      assign dec = pop & (fifo_head == ID_W'(gi));
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_cnt_reg[gi] <= '0;
        end else begin
          case ({inc, dec})
            2'b10:   out_cnt_reg[gi] <= out_cnt_reg[gi] + 1'b1;
            2'b01:   out_cnt_reg[gi] <= out_cnt_reg[gi] - 1'b1;
            default: out_cnt_reg[gi] <= out_cnt_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  assign cph_data_valid = issue_valid_reg;
  assign cph_key_valid  = issue_valid_reg;
  assign cph_key        = key_reg;
  assign cph_text       = text_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_data  = resp_data_reg;
  assign busy           = ~fifo_empty | issue_valid_reg;
  assign err_underflow  = err_reg;
  assign issue_count    = issue_count_reg;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Scoreboard bench for aes_pipe_scheduler with a behavioural fixed-latency
// cipher stand-in; a second, shallow-FIFO instance exercises the full case.
module tb_aes_pipe_scheduler;
  import aes_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  aes_pipe_scheduler_if #(.N_REQ(N), .ID_W(2), .DATA_W(128), .KEY_L(128)) m_if ();
  aes_pipe_scheduler_if #(.N_REQ(N), .ID_W(2), .DATA_W(128), .KEY_L(128)) s_if ();

  logic         cph_data_valid, cph_key_valid;
  logic [127:0] cph_key, cph_text;
  logic         cph_valid_out = 1'b0;
  logic [127:0] cph_cipher_text = '0;
  logic         busy, err_underflow;
  logic [31:0]  issue_count;

  logic         s_cdv, s_ckv;
  logic [127:0] s_key, s_text;
  logic         s_cvo = 1'b0;
  logic [127:0] s_ct = '0;
  logic         s_busy, s_err;
  logic [31:0]  s_cnt;

  aes_pipe_scheduler #(.N_REQ(N), .ID_W(2), .TAG_DEPTH(64), .MAX_OUT(16),
                       .DATA_W(128), .KEY_L(128)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(m_if),
    .cph_data_valid(cph_data_valid), .cph_key_valid(cph_key_valid),
    .cph_key(cph_key), .cph_text(cph_text),
    .cph_valid_out(cph_valid_out), .cph_cipher_text(cph_cipher_text),
    .busy(busy), .err_underflow(err_underflow), .issue_count(issue_count)
  );

  aes_pipe_scheduler #(.N_REQ(N), .ID_W(2), .TAG_DEPTH(8), .MAX_OUT(16),
                       .DATA_W(128), .KEY_L(128)) dut_s (
    .clk(clk), .reset(reset), .enable(1'b1), .bus(s_if),
    .cph_data_valid(s_cdv), .cph_key_valid(s_ckv),
    .cph_key(s_key), .cph_text(s_text),
    .cph_valid_out(s_cvo), .cph_cipher_text(s_ct),
    .busy(s_busy), .err_underflow(s_err), .issue_count(s_cnt)
  );

  typedef struct { logic [127:0] key; logic [127:0] text; int due; } cjob_t;
  typedef struct { logic [1:0] id; logic [127:0] data; } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_seen = 0;
  logic hold_out = 1'b0;
  logic force_pulse = 1'b0;
  logic real_prev = 1'b0;
  logic [1:0] last_id;
  logic [127:0] last_data;
  logic [127:0] tkey [N];
  logic [127:0] ttext [N];
  cjob_t cq[$];
  exp_t  sb[$];

  // Stand-in for the real cipher: reference vector, otherwise a keyed scramble
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_1234_c3c3_8765_0f0f_abcd_f0f0_9999;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cipher model, transfer capture and response checking, all at the falling edge
  always @(negedge clk) begin
    cjob_t c;
    exp_t e;
    if (!reset) begin
      cq.delete();
      sb.delete();
      cph_valid_out = 1'b0;
      real_prev = 1'b0;
    end else begin
      total++;
      if (real_prev) begin
        if (m_if.resp_valid !== 1'b1) begin
          bad++;
          $display("FAIL resp_latency: resp_valid=%b want 1 at cycle %0d", m_if.resp_valid, cyc);
        end else if (sb.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: id=%0d with empty scoreboard", m_if.resp_id);
        end else begin
          e = sb.pop_front();
          total++;
          if (m_if.resp_id !== e.id || m_if.resp_data !== e.data) begin
            bad++;
            $display("FAIL resp_match: got id=%0d data=%h want id=%0d data=%h",
                     m_if.resp_id, m_if.resp_data, e.id, e.data);
          end
        end
      end else if (m_if.resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL resp_spurious: resp_valid=%b want 0 at cycle %0d", m_if.resp_valid, cyc);
      end
      if (m_if.resp_valid === 1'b1) begin
        resp_seen++;
        last_id = m_if.resp_id;
        last_data = m_if.resp_data;
      end
      for (int i = 0; i < N; i++) begin
        if (m_if.req_valid[i] && m_if.req_ready[i]) begin
          e.id = 2'(i);
          e.data = fake_aes(m_if.req_key[i*128 +: 128], m_if.req_data[i*128 +: 128]);
          sb.push_back(e);
        end
      end
      if (cph_data_valid === 1'b1) begin
        c.key = cph_key;
        c.text = cph_text;
        c.due = cyc + LAT;
        cq.push_back(c);
      end
      real_prev = 1'b0;
      if (force_pulse) begin
        cph_valid_out = 1'b1;
        cph_cipher_text = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
      end else if (!hold_out && cq.size() != 0 && cq[0].due <= cyc) begin
        c = cq.pop_front();
        cph_valid_out = 1'b1;
        cph_cipher_text = fake_aes(c.key, c.text);
        real_prev = 1'b1;
      end else begin
        cph_valid_out = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_req(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      m_if.req_key[i*128 +: 128] = tkey[i];
      m_if.req_data[i*128 +: 128] = ttext[i];
    end
    m_if.req_valid = v;
  endtask

  task automatic do_reset();
    hold_out = 1'b0;
    force_pulse = 1'b0;
    apply_req('0);
    s_if.req_valid = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (sb.size() == 0 && cq.size() == 0 && busy === 1'b0 && m_if.resp_valid === 1'b0)
        done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: sb=%0d cq=%0d busy=%b want all idle", sb.size(), cq.size(), busy);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    apply_req('0);
    s_if.req_valid = '0;
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({cph_data_valid, cph_key_valid, m_if.resp_valid, busy, err_underflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {cph_data_valid, cph_key_valid, m_if.resp_valid, busy, err_underflow});
    end
    total++;
    if (issue_count !== 32'd0 || cph_key !== '0 || m_if.resp_data !== '0) begin
      bad++;
      $display("FAIL reset_regs: issue_count=%0d key=%h resp_data=%h want 0",
               issue_count, cph_key, m_if.resp_data);
    end
    total++;
    if (s_busy !== 1'b0 || s_err !== 1'b0 || s_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_small: busy=%b err=%b cnt=%0d want 0", s_busy, s_err, s_cnt);
    end
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < N; i++) begin
      s_if.req_key[i*128 +: 128] = tkey[i];
      s_if.req_data[i*128 +: 128] = ttext[i];
    end
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) s_if.req_valid = 4'b1111;
      #1;
      total++;
      if (k < 8 && s_if.req_ready !== (4'b0001 << (k % 4))) begin
        bad++;
        $display("FAIL full_grant%0d: ready=%b want %b", k, s_if.req_ready, 4'b0001 << (k % 4));
      end else if (k == 8 && s_if.req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL full_block: ready=%b want 0000", s_if.req_ready);
      end
    end
    tick();
    s_cvo = 1'b1;
    s_ct = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    #1;
    total++;
    if (s_if.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL full_same_cycle_pop: ready=%b want 0000", s_if.req_ready);
    end
    tick();
    s_cvo = 1'b0;
    #1;
    total++;
    if (s_if.req_ready === 4'b0000 || s_if.resp_valid !== 1'b1 || s_if.resp_id !== 2'd0 ||
        s_if.resp_data !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210) begin
      bad++;
      $display("FAIL full_unblock: ready=%b resp=%b id=%0d data=%h want ready!=0 resp=1 id=0",
               s_if.req_ready, s_if.resp_valid, s_if.resp_id, s_if.resp_data);
    end
    s_if.req_valid = '0;
    $display("test_fifo_full done");
  endtask

  task automatic test_single();
    int seen0;
    seen0 = resp_seen;
    tkey[2] = FIPS_KEY;
    ttext[2] = FIPS_PT;
    tick();
    enable = 1'b1;
    apply_req(4'b0100);
    #1;
    total++;
    if (m_if.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_grant: ready=%b want 0100", m_if.req_ready);
    end
    tick();
    apply_req('0);
    total++;
    if (cph_data_valid !== 1'b1 || cph_key_valid !== 1'b1 || cph_key !== FIPS_KEY || cph_text !== FIPS_PT) begin
      bad++;
      $display("FAIL single_issue: dv=%b kv=%b key=%h text=%h want 1 1 %h %h",
               cph_data_valid, cph_key_valid, cph_key, cph_text, FIPS_KEY, FIPS_PT);
    end
    drain();
    total++;
    if (resp_seen - seen0 != 1 || last_id !== 2'd2 || last_data !== FIPS_CT) begin
      bad++;
      $display("FAIL single_resp: count=%0d id=%0d data=%h want 1 2 %h",
               resp_seen - seen0, last_id, last_data, FIPS_CT);
    end
    total++;
    if (issue_count !== 32'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_after: issue_count=%0d busy=%b want 1 0", issue_count, busy);
    end
    tkey[2] = 128'h3333_0000_1111_2222_3333_4444_5555_6666;
    ttext[2] = 128'hcccc_2222_0202_2020_aaaa_5555_1234_0002;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) apply_req(4'b1111);
      #1;
      total++;
      if (m_if.req_ready !== (4'b0001 << (k % 4)) || (k > 0 && cph_data_valid !== 1'b1)) begin
        bad++;
        $display("FAIL rr_cycle%0d: ready=%b dv=%b want %b dv=%b",
                 k, m_if.req_ready, cph_data_valid, 4'b0001 << (k % 4), k > 0);
      end
    end
    tick();
    apply_req('0);
    total++;
    if (cph_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_last_issue: dv=%b want 1", cph_data_valid);
    end
    tick();
    total++;
    if (cph_data_valid !== 1'b0 || issue_count !== 32'd20) begin
      bad++;
      $display("FAIL rr_stop: dv=%b count=%0d want 0 20", cph_data_valid, issue_count);
    end
    drain();
    $display("test_round_robin done");
  endtask

  task automatic test_max_out();
    bit got;
    do_reset();
    enable = 1'b1;
    hold_out = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) apply_req(4'b0010);
      #1;
      total++;
      if (m_if.req_ready !== 4'b0010) begin
        bad++;
        $display("FAIL maxout_grant%0d: ready=%b want 0010", k, m_if.req_ready);
      end
    end
    tick();
    apply_req(4'b0011);
    #1;
    total++;
    if (m_if.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL maxout_block: ready=%b want 0001", m_if.req_ready);
    end
    tick();
    apply_req(4'b0010);
    #1;
    total++;
    if (m_if.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL maxout_hold: ready=%b want 0000", m_if.req_ready);
    end
    hold_out = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (m_if.resp_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || m_if.req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL maxout_resume: got_resp=%b ready=%b want 1 0010", got, m_if.req_ready);
    end
    tick();
    apply_req('0);
    drain();
    $display("test_max_out done");
  endtask

  task automatic test_enable();
    logic [N-1:0] last_ready;
    int g;
    enable = 1'b1;
    last_ready = '0;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) apply_req(4'b1111);
      #1;
      last_ready = m_if.req_ready;
    end
    for (int i = 0; i < N; i++) if (last_ready[i]) g = i;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) enable = 1'b0;
      #1;
      total++;
      if (m_if.req_ready !== 4'b0000 || cph_data_valid !== (k == 0)) begin
        bad++;
        $display("FAIL enable_off%0d: ready=%b dv=%b want 0000 dv=%b",
                 k, m_if.req_ready, cph_data_valid, k == 0);
      end
    end
    tick();
    enable = 1'b1;
    #1;
    total++;
    if (m_if.req_ready !== (4'b0001 << ((g + 1) % N))) begin
      bad++;
      $display("FAIL enable_resume: ready=%b want %b", m_if.req_ready, 4'b0001 << ((g + 1) % N));
    end
    tick();
    tick();
    apply_req('0);
    drain();
    $display("test_enable done");
  endtask

  task automatic test_underflow();
    logic [31:0] cnt0;
    cnt0 = issue_count;
    tick();
    force_pulse = 1'b1;
    tick();
    force_pulse = 1'b0;
    total++;
    if (err_underflow !== 1'b1 || m_if.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL underflow_set: err=%b resp=%b want 1 0", err_underflow, m_if.resp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (err_underflow !== 1'b1 || m_if.resp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL underflow_hold%0d: err=%b resp=%b busy=%b want 1 0 0",
                 k, err_underflow, m_if.resp_valid, busy);
      end
    end
    total++;
    if (issue_count !== cnt0) begin
      bad++;
      $display("FAIL underflow_count: issue_count=%0d want %0d", issue_count, cnt0);
    end
    do_reset();
    tick();
    total++;
    if (err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: err=%b want 0", err_underflow);
    end
    $display("test_underflow done");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tkey[i] = {4{8'h10 + 8'(i), 8'h22, 8'h3c, 8'h4d}};
      ttext[i] = {16{8'ha0 + 8'(i)}};
    end
    apply_req('0);
    s_if.req_valid = '0;
    s_if.req_key = '0;
    s_if.req_data = '0;
    test_reset();
    test_fifo_full();
    test_single();
    test_round_robin();
    test_max_out();
    test_enable();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_pipe_scheduler.md
Name: aes_pipe_scheduler

Overview:
- Shares one Top_PipelinedCipher instance among N_REQ requesters.
- Round-robin arbitration issues at most one (key, plaintext) pair per cycle into the cipher.
- Tracks the requester ID of each in-flight block in an in-order tag FIFO.
- Returns each ciphertext on a tagged response port.
- Sits between the host-side request queues and the cipher pipeline.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, equal to clog2(N_REQ).
- TAG_DEPTH, 64, tag FIFO entries; must be at least the cipher latency plus 2.
- MAX_OUT, 16, maximum in-flight blocks per requester.
- DATA_W, 128, block width.
- KEY_L, 128, key width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- enable  in  1  when low, no new grants are made; in-flight blocks still drain
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant, combinational
- req_key  in  N_REQ*KEY_L  per-requester key; requester i occupies slice i
- req_data  in  N_REQ*DATA_W  per-requester plaintext
- cph_data_valid  out  1  to cipher data_valid_in
- cph_key_valid  out  1  to cipher cipherkey_valid_in
- cph_key  out  KEY_L  to cipher cipher_key
- cph_text  out  DATA_W  to cipher plain_text
- cph_valid_out  in  1  from cipher valid_out
- cph_cipher_text  in  DATA_W  from cipher cipher_text
- resp_valid  out  1  response valid, one-cycle pulse, no backpressure
- resp_id  out  ID_W  originating requester
- resp_data  out  DATA_W  ciphertext
- busy  out  1  tag FIFO non-empty or issue register valid
- err_underflow  out  1  sticky protocol error
- issue_count  out  32  total granted blocks, wraps modulo 2^32

Behaviour:
- reset is asynchronous and active-low; clock is clk.
- Reset values: all registered outputs 0, round-robin pointer 0, tag FIFO empty, per-requester outstanding counters 0.
- Eligibility: requester i is eligible when req_valid[i] is set, enable=1, tag FIFO not full, and out_cnt[i] < MAX_OUT.
- Grant:
  - The first eligible index scanning from rr_ptr upward, with wrap, wins.
  - req_ready has exactly that bit set; all others are 0.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, rr_ptr <= (i+1) mod N_REQ; otherwise rr_ptr holds.
- Issue:
  - The cycle after a transfer, cph_data_valid = cph_key_valid = 1, with cph_key and cph_text holding the registered req slices.
  - With no transfer, both valids are 0 and key/text hold their last value.
  - Sustained issue rate is 1 block per cycle.
- Tag push: on the transfer cycle, ID i is pushed and out_cnt[i] increments.
- Tag pop:
  - On cph_valid_out=1 with the FIFO non-empty, the head is popped.
  - Next cycle: resp_valid=1, resp_id=head, resp_data=registered cph_cipher_text, and out_cnt[head] decrements.
  - Response latency from cph_valid_out is 1 cycle.
- Simultaneous events:
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Increment and decrement of the same out_cnt in the same cycle leave it unchanged.
- Full FIFO: no grant is made; a same-cycle pop does not unblock a grant; the next cycle may grant.
- Underflow:
  - cph_valid_out=1 with the FIFO empty sets err_underflow (held until reset).
  - No response is generated; the FIFO and counters are unchanged.
- enable deasserted mid-stream:
  - Grants stop that cycle.
  - An already-registered issue still presents to the cipher.
  - All outstanding responses are still delivered.
- Ordering: responses leave in issue order, because the cipher is in-order. Per-requester order is preserved.
- Reset mid-operation: FIFO, counters and pointer clear; later cipher outputs from pre-reset issues raise err_underflow, which is expected; the bench must flush.

Decomposition:
- Package aes_sched_pkg holds ID_W, DATA_W and KEY_L defaults, the clog2 helper for FIFO pointer width, and the FIPS-197 test constants.
- One sub-module: aes_tag_fifo, a synchronous FIFO of width ID_W and depth TAG_DEPTH with full/empty flags and simultaneous push/pop.
- Arbiter logic stays inline.

Test Plan:
- Single request, FIPS-197 vector:
  - Stimulus: requester 2 sends key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff.
  - Response: one resp_valid with resp_id=2 and resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, exactly 1 cycle after cph_valid_out.
  - issue_count=1 and busy=0 afterwards.
- All requesters always valid, 20 cycles, from reset:
  - Grant sequence is 0,1,2,3,0,1,...
  - cph_data_valid is high for 20 consecutive cycles.
  - Responses arrive in the same ID order.
- Requester 1 only, cipher responses withheld by the model:
  - After 16 grants, req_ready[1]=0 and requester 0 is still granted.
  - After one response for requester 1, its grants resume.
- enable=0 for 5 cycles mid-burst:
  - No cph_data_valid during the disabled cycles apart from the one registered issue.
  - All outstanding responses are delivered.
  - Granting resumes at rr_ptr.
- Tag FIFO full:
  - TAG_DEPTH=8 with cipher output stalled: all req_ready go low after 8 grants.
  - A pop re-enables granting on the following cycle.
- Forced cph_valid_out with an empty FIFO:
  - err_underflow=1 and stays high.
  - resp_valid stays 0.
  - Only reset clears err_underflow.
